// File: rtl/ball_motion_pkg.sv
// Shared constants and types for the ball object: screen geometry,
// colour widths, coordinate type and ball state encodings.
package ball_motion_pkg;

   localparam int MAX_X        = 640;
   localparam int MAX_Y        = 480;
   localparam int PADDLE_Y_LOW = 470;

   localparam int COORD_W = 11;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int RGB_R_W = 5;
   localparam int RGB_G_W = 6;
   localparam int RGB_B_W = 5;

   localparam logic [RGB_R_W-1:0] BALL_COLOR_R = 5'b11111;
   localparam logic [RGB_G_W-1:0] BALL_COLOR_G = 6'b111111;
   localparam logic [RGB_B_W-1:0] BALL_COLOR_B = 5'b11111;

   // Ball states: held on paddle, in flight, serving a miss, game over
   typedef logic [1:0] ball_state_t;
   localparam ball_state_t S_IDLE = 2'd0;
   localparam ball_state_t S_MOVE = 2'd1;
   localparam ball_state_t S_MISS = 2'd2;
   localparam ball_state_t S_OVER = 2'd3;

endpackage

// File: rtl/ball_collide.sv
// Combinational collision resolver: given the current position and
// direction, decides the next direction and whether the ball is missed.
// Directions are one bit each: dx_pos=1 means +V, dy_pos=1 means downward.
module ball_collide
   import ball_motion_pkg::*;
#(
   parameter int BALL_SIZE     = 8,
   parameter int BALL_VELOCITY = 2
) (
   input  coord_t ball_x,
   input  coord_t ball_y,
   input  logic   dx_pos,
   input  logic   dy_pos,
   input  coord_t paddle_left,
   input  coord_t paddle_right,
   input  logic   brick_pend,
   output logic   dx_pos_next,
   output logic   dy_pos_next,
   output logic   miss_det
);

   // One extra bit so sums near the screen edge cannot wrap
   logic [COORD_W:0] xe, ye, pl, pr;
   logic hit_left, hit_right, hit_top, hit_paddle;

   assign xe = {1'b0, ball_x};
   assign ye = {1'b0, ball_y};
   assign pl = {1'b0, paddle_left};
   assign pr = {1'b0, paddle_right};

   assign hit_left   = xe < (COORD_W+1)'(BALL_VELOCITY);
   assign hit_right  = (xe + (COORD_W+1)'(BALL_SIZE + BALL_VELOCITY)) > (COORD_W+1)'(MAX_X);
   assign miss_det   = dy_pos && ((ye + (COORD_W+1)'(BALL_SIZE + BALL_VELOCITY)) > (COORD_W+1)'(MAX_Y));
   assign hit_top    = ye < (COORD_W+1)'(BALL_VELOCITY);
   // Only a ball whose bottom is still at or above the paddle top can bounce
   assign hit_paddle = dy_pos
                    && ((ye + (COORD_W+1)'(BALL_SIZE)) <= (COORD_W+1)'(PADDLE_Y_LOW))
                    && ((ye + (COORD_W+1)'(BALL_SIZE + BALL_VELOCITY)) > (COORD_W+1)'(PADDLE_Y_LOW))
                    && ((xe + (COORD_W+1)'(BALL_SIZE - 1)) >= pl)
                    && (xe <= pr);

   // Horizontal reflection off the side walls
   always_comb begin
      dx_pos_next = dx_pos;
      if (hit_left)       dx_pos_next = 1'b1;
      else if (hit_right) dx_pos_next = 1'b0;
   end

   // Vertical reflection in priority order: miss, top wall, paddle, brick
   always_comb begin
      dy_pos_next = dy_pos;
      if (miss_det)        dy_pos_next = dy_pos;
      else if (hit_top)    dy_pos_next = 1'b1;
      else if (hit_paddle) dy_pos_next = 1'b0;
      else if (brick_pend) dy_pos_next = ~dy_pos;
   end

endmodule

// File: rtl/ball_motion.sv
// Ball object: holds the ball on the paddle until served, moves it once
// per ref_tick, handles misses and lives, and renders the ball pixel.
module ball_motion
   import ball_motion_pkg::*;
#(
   parameter int PADDLE_LENGTH = 64,
   parameter int BALL_SIZE     = 8,
   parameter int BALL_VELOCITY = 2,
   parameter int LIVES         = 3,
   parameter int MISS_TICKS    = 60
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ref_tick,
   input  logic               launch,
   input  logic               brick_hit,
   input  coord_t             paddle_left,
   input  coord_t             paddle_right,
   input  coord_t             pix_x,
   input  coord_t             pix_y,
   output logic               ball_on,
   output logic [RGB_R_W-1:0] ball_rgb_r,
   output logic [RGB_G_W-1:0] ball_rgb_g,
   output logic [RGB_B_W-1:0] ball_rgb_b,
   output coord_t             ball_x,
   output coord_t             ball_y,
   output logic               miss,
   output logic [1:0]         lives,
   output logic               game_over
);

   localparam coord_t X_RST = coord_t'(PADDLE_LENGTH/2 - BALL_SIZE/2);
   localparam coord_t Y_RST = coord_t'(PADDLE_Y_LOW - BALL_SIZE);
   localparam coord_t VEL   = coord_t'(BALL_VELOCITY);
   localparam int     CNT_W = (MISS_TICKS > 1) ? $clog2(MISS_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MISS_TICKS - 1);

   ball_state_t      state;
   logic             dx_pos, dy_pos;
   logic             brick_pend;
   logic [CNT_W-1:0] miss_cnt;
   logic             dx_pos_next, dy_pos_next, miss_det;
   coord_t           span, centre_x;

   // Serve position centred on the paddle
   assign span     = paddle_right - paddle_left + coord_t'(1);
   assign centre_x = paddle_left + (span >> 1) - coord_t'(BALL_SIZE/2);

   // A hit arriving on the tick itself counts for that tick
   ball_collide #(
      .BALL_SIZE     (BALL_SIZE),
      .BALL_VELOCITY (BALL_VELOCITY)
   ) u_collide (
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .dx_pos       (dx_pos),
      .dy_pos       (dy_pos),
      .paddle_left  (paddle_left),
      .paddle_right (paddle_right),
      .brick_pend   (brick_pend | brick_hit),
      .dx_pos_next  (dx_pos_next),
      .dy_pos_next  (dy_pos_next),
      .miss_det     (miss_det)
   );

   // Ball FSM, position, direction, lives and miss timer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         ball_x     <= X_RST;
         ball_y     <= Y_RST;
         dx_pos     <= 1'b1;
         dy_pos     <= 1'b0;
         lives      <= 2'(LIVES);
         miss       <= 1'b0;
         brick_pend <= 1'b0;
         miss_cnt   <= '0;
      end else begin
         miss <= 1'b0;
         case (state)
            S_IDLE: begin
               brick_pend <= 1'b0;
               if (ref_tick) begin
                  if (launch) begin
                     state  <= S_MOVE;
                     dx_pos <= 1'b1;
                     dy_pos <= 1'b0;
                  end else begin
                     ball_x <= centre_x;
                     ball_y <= Y_RST;
                  end
               end
            end
            S_MOVE: begin
               if (ref_tick) begin
                  brick_pend <= 1'b0;
                  if (miss_det) begin
                     state <= S_MISS;
                     miss  <= 1'b1;
                     if (lives != 2'd0) lives <= lives - 2'd1;
                  end else begin
                     dx_pos <= dx_pos_next;
                     dy_pos <= dy_pos_next;
                     ball_x <= dx_pos_next ? ball_x + VEL : ball_x - VEL;
                     ball_y <= dy_pos_next ? ball_y + VEL : ball_y - VEL;
                  end
               end else if (brick_hit) begin
                  brick_pend <= 1'b1;
               end
            end
            S_MISS: begin
               brick_pend <= 1'b0;
               if (ref_tick) begin
                  if (miss_cnt == CNT_LAST) begin
                     miss_cnt <= '0;
                     state    <= (lives == 2'd0) ? S_OVER : S_IDLE;
                  end else begin
                     miss_cnt <= miss_cnt + 1'b1;
                  end
               end
            end
            default: begin
               brick_pend <= 1'b0;
            end
         endcase
      end
   end

   assign game_over = (state == S_OVER);

   // Pixel-inside-ball test, suppressed once the game is over
   logic [COORD_W:0] px, py, bx, by;
   assign px = {1'b0, pix_x};
   assign py = {1'b0, pix_y};
   assign bx = {1'b0, ball_x};
   assign by = {1'b0, ball_y};
   assign ball_on = (state != S_OVER)
                 && (px >= bx) && (px <= bx + (COORD_W+1)'(BALL_SIZE - 1))
                 && (py >= by) && (py <= by + (COORD_W+1)'(BALL_SIZE - 1));

   assign ball_rgb_r = BALL_COLOR_R;
   assign ball_rgb_g = BALL_COLOR_G;
   assign ball_rgb_b = BALL_COLOR_B;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: serve, walls, paddle, bricks, misses,
// game over and reset, with hand-computed expected positions.
module tb_ball_motion;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ref_tick = 1'b0;
   logic        launch = 1'b0;
   logic        brick_hit = 1'b0;
   logic [10:0] paddle_left = 11'd0;
   logic [10:0] paddle_right = 11'd63;
   logic [10:0] pix_x = 11'd0;
   logic [10:0] pix_y = 11'd0;
   logic        ball_on;
   logic [4:0]  ball_rgb_r, ball_rgb_b;
   logic [5:0]  ball_rgb_g;
   logic [10:0] ball_x, ball_y;
   logic        miss;
   logic [1:0]  lives;
   logic        game_over;

   int total = 0;
   int bad   = 0;

   ball_motion dut (
      .clk          (clk),
      .reset        (reset),
      .ref_tick     (ref_tick),
      .launch       (launch),
      .brick_hit    (brick_hit),
      .paddle_left  (paddle_left),
      .paddle_right (paddle_right),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .ball_on      (ball_on),
      .ball_rgb_r   (ball_rgb_r),
      .ball_rgb_g   (ball_rgb_g),
      .ball_rgb_b   (ball_rgb_b),
      .ball_x       (ball_x),
      .ball_y       (ball_y),
      .miss         (miss),
      .lives        (lives),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int ex, input int ey);
      chk({tag, ".x"}, 32'(ball_x), 32'(ex));
      chk({tag, ".y"}, 32'(ball_y), 32'(ey));
   endtask

   task automatic tick(input logic l, input logic b);
      @(negedge clk);
      ref_tick = 1'b1; launch = l; brick_hit = b;
      @(negedge clk);
      ref_tick = 1'b0; launch = 1'b0; brick_hit = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
   endtask

   task automatic brick_pulse();
      @(negedge clk); brick_hit = 1'b1;
      @(negedge clk); brick_hit = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic on_at(input string tag, input int x, input int y, input logic exp);
      pix_x = 11'(x); pix_y = 11'(y);
      #1;
      chk(tag, 32'(ball_on), 32'(exp));
   endtask

   // Serve from IDLE and drop straight into a miss; paddle moved out of reach
   task automatic serve_and_miss(input string tag, input int exp_lives);
      bit seen;
      paddle_left = 11'd300; paddle_right = 11'd363;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      paddle_left = 11'd700; paddle_right = 11'd750;
      tick(1'b0, 1'b0);
      brick_pulse();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1'b0, 1'b0);
         if (miss) seen = 1'b1;
      end
      chk({tag, ".miss_seen"}, 32'(seen), 32'd1);
      chk({tag, ".lives"}, 32'(lives), 32'(exp_lives));
      chk_pos({tag, ".frozen"}, 342, 472);
      ticks(60);
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      #12;
      chk_pos("rst", 28, 462);
      chk("rst.lives", 32'(lives), 32'd3);
      chk("rst.miss", 32'(miss), 32'd0);
      chk("rst.over", 32'(game_over), 32'd0);
      @(negedge clk); reset = 1'b0;
      on_at("on.28_462", 28, 462, 1'b1);
      on_at("on.36_462", 36, 462, 1'b0);
      on_at("on.35_469", 35, 469, 1'b1);
      on_at("on.27_462", 27, 462, 1'b0);
      on_at("on.28_470", 28, 470, 1'b0);
      chk("rgb.r", 32'(ball_rgb_r), 32'd31);
      chk("rgb.g", 32'(ball_rgb_g), 32'd63);
      chk("rgb.b", 32'(ball_rgb_b), 32'd31);

      // Centre on paddle, serve, first move
      paddle_left = 11'd200; paddle_right = 11'd263;
      tick(1'b0, 1'b0);
      chk_pos("idle.centre", 228, 462);
      tick(1'b1, 1'b0);
      chk_pos("launch.hold", 228, 462);
      tick(1'b0, 1'b0);
      chk_pos("move1", 230, 460);

      // Brick between ticks flips upward motion; then paddle bounce
      tick(1'b0, 1'b0);
      chk_pos("move2", 232, 458);
      brick_pulse();
      chk_pos("brick.no_move", 232, 458);
      tick(1'b0, 1'b0);
      chk_pos("brick.flip", 234, 460);
      tick(1'b0, 1'b0);
      chk_pos("brick.cleared", 236, 462);
      tick(1'b0, 1'b0);
      chk_pos("paddle.bounce", 238, 460);
      tick(1'b0, 1'b0);
      chk_pos("paddle.up", 240, 458);

      // Asynchronous reset mid-flight
      @(negedge clk); reset = 1'b1;
      #1;
      chk_pos("rst.midmove", 28, 462);
      @(negedge clk); reset = 1'b0;

      // Right wall, then top wall and brick absorbed at the top
      paddle_left = 11'd575; paddle_right = 11'd638;
      tick(1'b0, 1'b0);
      chk_pos("r.centre", 603, 462);
      tick(1'b1, 1'b0);
      ticks(14);
      chk_pos("r.edge", 631, 434);
      tick(1'b0, 1'b0);
      chk_pos("r.bounce", 629, 432);
      tick(1'b0, 1'b0);
      chk_pos("r.left", 627, 430);
      ticks(214);
      chk_pos("t.y2", 199, 2);
      tick(1'b0, 1'b0);
      chk_pos("t.y0", 197, 0);
      tick(1'b0, 1'b1);
      chk_pos("t.bounce_brick", 195, 2);
      tick(1'b0, 1'b0);
      chk_pos("t.down", 193, 4);

      // Paddle not under the ball: falls through to a miss
      do_reset();
      paddle_left = 11'd200; paddle_right = 11'd263;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      brick_pulse();
      tick(1'b0, 1'b0);
      chk_pos("m.down", 232, 462);
      paddle_left = 11'd300; paddle_right = 11'd363;
      tick(1'b0, 1'b0);
      chk_pos("m.no_bounce", 234, 464);
      ticks(4);
      chk_pos("m.y472", 242, 472);
      chk("m.no_miss_yet", 32'(miss), 32'd0);
      tick(1'b0, 1'b0);
      chk("m.miss_pulse", 32'(miss), 32'd1);
      chk("m.lives2", 32'(lives), 32'd2);
      chk_pos("m.frozen", 242, 472);
      @(negedge clk);
      chk("m.miss_clear", 32'(miss), 32'd0);
      on_at("m.on", 242, 472, 1'b1);
      ticks(60);
      chk_pos("m.held", 242, 472);
      tick(1'b0, 1'b0);
      chk_pos("m.reserve", 328, 462);

      // Two more misses to game over
      serve_and_miss("miss2", 1);
      chk("miss2.over", 32'(game_over), 32'd0);
      serve_and_miss("miss3", 0);
      chk("over.flag", 32'(game_over), 32'd1);
      on_at("over.on", 342, 472, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("over.launch_ign", 32'(game_over), 32'd1);
      chk_pos("over.held", 342, 472);
      chk("over.lives", 32'(lives), 32'd0);

      do_reset();
      chk("rst2.lives", 32'(lives), 32'd3);
      chk("rst2.over", 32'(game_over), 32'd0);
      chk_pos("rst2", 28, 462);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
